// File: rtl/vga_timing_pkg.sv
// Shared 800x600 timing defaults, 3-3-2 colour field positions and the
// per-pixel flag record carried down the output pipeline.
package vga_timing_pkg;

    localparam int H_ACTIVE_DEF = 800;
    localparam int H_FP_DEF     = 40;
    localparam int H_SYNC_DEF   = 128;
    localparam int H_BP_DEF     = 88;
    localparam int V_ACTIVE_DEF = 600;
    localparam int V_FP_DEF     = 1;
    localparam int V_SYNC_DEF   = 4;
    localparam int V_BP_DEF     = 23;
    localparam int X_OFS_DEF    = 144;
    localparam int Y_OFS_DEF    = 60;

    // The source image is 256x240, shown pixel-doubled.
    localparam int PIC_W = 512;
    localparam int PIC_H = 480;

    localparam int R_MSB = 7;
    localparam int R_LSB = 5;
    localparam int G_MSB = 4;
    localparam int G_LSB = 2;
    localparam int B_MSB = 1;
    localparam int B_LSB = 0;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank;
        logic win;
        logic frame_start;
    } pix_flags_t;

    localparam pix_flags_t FLAGS_RESET = '{hsync: 1'b0, vsync: 1'b0, blank: 1'b1,
                                           win: 1'b0, frame_start: 1'b0};

    function automatic logic in_range(input logic [31:0] val, input int lo, input int hi);
        return (val >= $unsigned(lo)) && (val <= $unsigned(hi));
    endfunction

endpackage

// File: rtl/vga_counter.sv
// Horizontal/vertical beam counters plus the stage-0 decode of sync,
// active area and frame start from the current counter value.
module vga_counter
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_ce,
    output logic [HW-1:0] hcnt,
    output logic [VW-1:0] vcnt,
    output logic          active,
    output logic          hsync,
    output logic          vsync,
    output logic          frame_start
);

    logic [HW-1:0] hcnt_d, hcnt_q;
    logic [VW-1:0] vcnt_d, vcnt_q;
    logic [31:0]   h, v;

    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (pix_ce) begin
            if (32'(hcnt_q) == $unsigned(H_TOTAL - 1)) begin
                hcnt_d = '0;
                vcnt_d = (32'(vcnt_q) == $unsigned(V_TOTAL - 1)) ? '0 : vcnt_q + 1'b1;
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    assign h           = 32'(hcnt_q);
    assign v           = 32'(vcnt_q);
    assign hcnt        = hcnt_q;
    assign vcnt        = vcnt_q;
    assign active      = (h < $unsigned(H_ACTIVE)) && (v < $unsigned(V_ACTIVE));
    assign hsync       = in_range(h, H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC - 1);
    assign vsync       = in_range(v, V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC - 1);
    assign frame_start = (hcnt_q == '0) && (vcnt_q == '0);

endmodule

// File: rtl/vga_scan_out.sv
// VGA scan-out: reads a 256x240 source through a synchronous RAM and shows
// it pixel-doubled inside a border, with all outputs two pix_ce cycles late.
module vga_scan_out
    import vga_timing_pkg::*;
#(
    parameter int         H_ACTIVE = H_ACTIVE_DEF,
    parameter int         H_FP     = H_FP_DEF,
    parameter int         H_SYNC   = H_SYNC_DEF,
    parameter int         H_BP     = H_BP_DEF,
    parameter int         V_ACTIVE = V_ACTIVE_DEF,
    parameter int         V_FP     = V_FP_DEF,
    parameter int         V_SYNC   = V_SYNC_DEF,
    parameter int         V_BP     = V_BP_DEF,
    parameter int         X_OFS    = X_OFS_DEF,
    parameter int         Y_OFS    = Y_OFS_DEF,
    parameter logic [7:0] BORDER   = 8'h00,
    localparam int        HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    localparam int        VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_ce,
    output logic [15:0] rd_addr,
    output logic        rd_en,
    input  logic [7:0]  rd_data,
    output logic        hsync,
    output logic        vsync,
    output logic        blank,
    output logic [7:0]  rgb,
    output logic        frame_start
);

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          active, hs0, vs0, fs0, window;
    logic [7:0]    src_x, src_y;
    pix_flags_t    s0, s1_d, s1_q;
    logic          hsync_d, hsync_q, vsync_d, vsync_q, blank_d, blank_q, fs_d, fs_q;
    logic [7:0]    rgb_d, rgb_q;

    vga_counter #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_counter (
        .clk(clk), .reset(reset), .pix_ce(pix_ce),
        .hcnt(hcnt), .vcnt(vcnt), .active(active),
        .hsync(hs0), .vsync(vs0), .frame_start(fs0)
    );

    // Blanking wins: a window reaching past the active area is clipped.
    assign window = active
                 && in_range(32'(hcnt), X_OFS, X_OFS + PIC_W - 1)
                 && in_range(32'(vcnt), Y_OFS, Y_OFS + PIC_H - 1);
    assign src_x  = 8'((hcnt - HW'(X_OFS)) >> 1);
    assign src_y  = 8'((vcnt - VW'(Y_OFS)) >> 1);

    assign rd_en   = window && !reset;
    assign rd_addr = rd_en ? {src_y, src_x} : 16'h0000;

    assign s0 = '{hsync: hs0, vsync: vs0, blank: !active, win: window, frame_start: fs0};

    // Stage 1 waits out the RAM latency; stage 2 merges rd_data into rgb.
    always_comb begin
        s1_d    = s1_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        blank_d = blank_q;
        fs_d    = fs_q;
        rgb_d   = rgb_q;
        if (pix_ce) begin
            s1_d    = s0;
            hsync_d = s1_q.hsync;
            vsync_d = s1_q.vsync;
            blank_d = s1_q.blank;
            fs_d    = s1_q.frame_start;
            if (s1_q.blank)    rgb_d = 8'h00;
            else if (s1_q.win) rgb_d = rd_data;
            else               rgb_d = BORDER;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q    <= FLAGS_RESET;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
            blank_q <= 1'b1;
            fs_q    <= 1'b0;
            rgb_q   <= 8'h00;
        end else begin
            s1_q    <= s1_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            blank_q <= blank_d;
            fs_q    <= fs_d;
            rgb_q   <= rgb_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign blank       = blank_q;
    assign rgb         = rgb_q;
    assign frame_start = fs_q;

endmodule
